// File: rtl/mips_pkg.sv
// Shared MIPS definitions: primary opcodes (also used by the control
// decoder) and the instruction-fetch state encoding.
package mips_pkg;

    localparam logic [5:0] RFORMAT = 6'd0;
    localparam logic [5:0] JAL     = 6'd3;
    localparam logic [5:0] BEQ     = 6'd4;
    localparam logic [5:0] ADDI    = 6'd8;
    localparam logic [5:0] ANDI    = 6'd12;
    localparam logic [5:0] LW      = 6'd35;
    localparam logic [5:0] SW      = 6'd43;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/opcode_check.sv
// Combinational legal-opcode detector: flags any primary opcode that the
// control decoder does not implement.
module opcode_check
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    output logic       illegal
);

    // Anything outside the implemented opcode set is illegal.
    always_comb begin
        illegal = 1'b1;
        case (opcode)
            RFORMAT, JAL, BEQ, ADDI, ANDI, LW, SW: illegal = 1'b0;
            default:                               illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, reads instruction memory over a
// req/ready handshake and hands instructions to decode over valid/accept.
// Redirects from the datapath flush any wrong-path fetch.
// Optional feature macro: IFETCH_OPCODE_CHECK_EN adds the illegal_op output
// and stalls in HOLD on an illegal opcode until redirect or reset.
//
// Handshakes: imem side - a read completes in a cycle with imem_req=1 and
// imem_ready=1; imem_addr holds until then. Decode side - an instruction is
// consumed in a cycle with instr_valid=1 and instr_accept=1; instr, pc and
// pc_plus4 hold until then. redirect_en overrides both in its cycle.
module instr_fetch
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic              instr_valid,
    input  logic              instr_accept,
    output logic [31:0]       instr,
    output logic [5:0]        opcode,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    input  logic              redirect_en,
    input  logic [ADDR_W-1:0] redirect_pc,
`ifdef IFETCH_OPCODE_CHECK_EN
    output logic              illegal_op,
`endif
    output fetch_state_e      dbg_state
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] drain_addr_q, drain_addr_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_plus4_q, pc_plus4_d;
    logic              valid_q, valid_d;
    logic              illegal_q, illegal_d;

    logic [ADDR_W-1:0] redirect_target;
    logic [ADDR_W-1:0] fetch_pc_next;
    logic              rdata_illegal;

    assign redirect_target = redirect_pc & ALIGN_MASK;
    assign fetch_pc_next   = fetch_pc_q + ADDR_W'(4);

`ifdef IFETCH_OPCODE_CHECK_EN
    opcode_check u_opcode_check (
        .opcode  (imem_rdata[31:26]),
        .illegal (rdata_illegal)
    );
    assign illegal_op = illegal_q;
`else
    assign rdata_illegal = 1'b0;
`endif

    // Next-state and handshake outputs; redirect is checked first in every state.
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        drain_addr_d = drain_addr_q;
        instr_d      = instr_q;
        pc_d         = pc_q;
        pc_plus4_d   = pc_plus4_q;
        valid_d      = valid_q;
        illegal_d    = illegal_q;
        imem_req     = (state_q == FETCH) || (state_q == DRAIN);
        imem_addr    = (state_q == DRAIN) ? drain_addr_q : fetch_pc_q;

        case (state_q)
            FETCH: begin
                if (redirect_en) begin
                    fetch_pc_d = redirect_target;
                    if (!imem_ready) begin
                        // Read still in flight at the old address: drain it.
                        state_d      = DRAIN;
                        drain_addr_d = fetch_pc_q;
                    end
                end else if (imem_ready) begin
                    instr_d    = imem_rdata;
                    pc_d       = fetch_pc_q;
                    pc_plus4_d = fetch_pc_next;
                    fetch_pc_d = fetch_pc_next;
                    valid_d    = 1'b1;
                    illegal_d  = rdata_illegal;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (redirect_en) begin
                    valid_d    = 1'b0;
                    illegal_d  = 1'b0;
                    fetch_pc_d = redirect_target;
                    state_d    = FETCH;
                end else if (instr_accept && !illegal_q) begin
                    valid_d = 1'b0;
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                if (redirect_en) begin
                    fetch_pc_d = redirect_target;
                end
                if (imem_ready) begin
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= FETCH;
            fetch_pc_q   <= RESET_PC & ALIGN_MASK;
            drain_addr_q <= RESET_PC & ALIGN_MASK;
            instr_q      <= '0;
            pc_q         <= '0;
            pc_plus4_q   <= '0;
            valid_q      <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            drain_addr_q <= drain_addr_d;
            instr_q      <= instr_d;
            pc_q         <= pc_d;
            pc_plus4_q   <= pc_plus4_d;
            valid_q      <= valid_d;
            illegal_q    <= illegal_d;
        end
    end

    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign pc          = pc_q;
    assign pc_plus4    = pc_plus4_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a variable-latency memory model and a
// scoreboard of expected presented PCs.
module tb_instr_fetch;
    import mips_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_accept = 1'b0;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        redirect_en = 1'b0;
    logic [31:0] redirect_pc = '0;
`ifdef IFETCH_OPCODE_CHECK_EN
    logic        illegal_op;
`endif
    fetch_state_e dbg_state;

    instr_fetch #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .instr_accept (instr_accept),
        .instr        (instr),
        .opcode       (opcode),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .redirect_en  (redirect_en),
        .redirect_pc  (redirect_pc),
`ifdef IFETCH_OPCODE_CHECK_EN
        .illegal_op   (illegal_op),
`endif
        .dbg_state    (dbg_state)
    );

    // ---------------- memory model ----------------
    function automatic logic [31:0] word_for(input logic [31:0] a);
        logic [5:0] op;
        if (a == 32'h200) return {6'd2, 26'h0123456};
        case (a[4:2])
            3'd0: op = 6'd35;
            3'd1: op = 6'd43;
            3'd2: op = 6'd0;
            3'd3: op = 6'd8;
            3'd4: op = 6'd4;
            3'd5: op = 6'd12;
            default: op = 6'd3;
        endcase
        return {op, a[27:2]};
    endfunction

    int lat = 0;
    int wait_cnt = 0;
    assign imem_ready = imem_req && (wait_cnt >= lat);
    assign imem_rdata = word_for(imem_addr);

    always @(posedge clk) begin
        if (reset || !imem_req || imem_ready) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];
    logic expect_stall = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every consumed instruction must be the next expected PC.
    always @(negedge clk) begin
        if (!reset && instr_valid && instr_accept && !redirect_en && !expect_stall) begin
            logic [31:0] e;
            if (exp_q.size() == 0) begin
                check("sb_unexpected_pc", pc, 32'hxxxx_xxxx);
            end else begin
                e = exp_q.pop_front();
                check("sb_pc", pc, e);
                check("sb_pc_plus4", pc_plus4, e + 32'd4);
                check("sb_instr", instr, word_for(e));
                check("sb_opcode", 32'(opcode), 32'(word_for(e) >> 26));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        // reset
        tick();
        tick();
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_pc", pc, 32'd0);
        check("rst_pc_plus4", pc_plus4, 32'd0);
        check("rst_state", 32'(dbg_state), 32'(FETCH));
        reset = 1'b0;
        instr_accept = 1'b1;
        lat = 0;

        // zero-wait streaming: one instruction every 2 cycles
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(32'(k * 4));
            check("stream_req", 32'(imem_req), 32'd1);
            check("stream_addr", imem_addr, 32'(k * 4));
            check("stream_valid_lo", 32'(instr_valid), 32'd0);
            tick();
            check("stream_valid_hi", 32'(instr_valid), 32'd1);
            check("stream_pc", pc, 32'(k * 4));
            check("stream_pc_plus4", pc_plus4, 32'(k * 4 + 4));
            tick();
        end

        // slow memory, decode back-pressure
        instr_accept = 1'b0;
        lat = 3;
        exp_q.push_back(32'h10);
        for (int c = 0; c < 4; c++) begin
            check("wait_req", 32'(imem_req), 32'd1);
            check("wait_addr", imem_addr, 32'h10);
            check("wait_valid", 32'(instr_valid), 32'd0);
            tick();
        end
        for (int c = 0; c < 4; c++) begin
            check("hold_valid", 32'(instr_valid), 32'd1);
            check("hold_instr", instr, word_for(32'h10));
            check("hold_no_req", 32'(imem_req), 32'd0);
            tick();
        end
        instr_accept = 1'b1;
        tick();
        check("after_accept_valid", 32'(instr_valid), 32'd0);
        check("after_accept_addr", imem_addr, 32'h14);

        // redirect during HOLD wins over accept
        lat = 0;
        tick();
        check("pre_redir_valid", 32'(instr_valid), 32'd1);
        check("pre_redir_pc", pc, 32'h14);
        redirect_en = 1'b1;
        redirect_pc = 32'h43;
        tick();
        redirect_en = 1'b0;
        check("hold_redir_valid", 32'(instr_valid), 32'd0);
        check("hold_redir_addr", imem_addr, 32'h40);
        exp_q.push_back(32'h40);
        tick();
        check("hold_redir_pc", pc, 32'h40);
        tick();

        // redirect in FETCH without ready -> DRAIN, second redirect wins
        lat = 3;
        check("drain_pre_addr", imem_addr, 32'h44);
        redirect_en = 1'b1;
        redirect_pc = 32'h80;
        tick();
        check("drain_state", 32'(dbg_state), 32'(DRAIN));
        check("drain_addr", imem_addr, 32'h44);
        redirect_pc = 32'h100;
        tick();
        redirect_en = 1'b0;
        check("drain_addr_stable", imem_addr, 32'h44);
        check("drain_req", 32'(imem_req), 32'd1);
        tick();
        check("drain_ready", 32'(imem_ready), 32'd1);
        check("drain_state2", 32'(dbg_state), 32'(DRAIN));
        tick();
        check("post_drain_state", 32'(dbg_state), 32'(FETCH));
        check("post_drain_addr", imem_addr, 32'h100);
        check("post_drain_valid", 32'(instr_valid), 32'd0);
        lat = 0;
        exp_q.push_back(32'h100);
        tick();
        check("post_drain_pc", pc, 32'h100);
        tick();

        // redirect in FETCH with ready discards data; PC wrap
        check("wrap_pre_addr", imem_addr, 32'h104);
        redirect_en = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_en = 1'b0;
        check("fetch_redir_valid", 32'(instr_valid), 32'd0);
        check("fetch_redir_addr", imem_addr, 32'hFFFF_FFFC);
        instr_accept = 1'b0;
        exp_q.push_back(32'hFFFF_FFFC);
        tick();
        check("wrap_pc", pc, 32'hFFFF_FFFC);
        check("wrap_pc_plus4", pc_plus4, 32'h0);
        instr_accept = 1'b1;
        exp_q.push_back(32'h0);
        tick();
        check("wrap_next_addr", imem_addr, 32'h0);
        tick();
        check("wrap_next_pc", pc, 32'h0);
        tick();

        // opcode 2
        redirect_en = 1'b1;
        redirect_pc = 32'h200;
        tick();
        redirect_en = 1'b0;
        check("op2_addr", imem_addr, 32'h200);
`ifdef IFETCH_OPCODE_CHECK_EN
        expect_stall = 1'b1;
        tick();
        check("op2_opcode", 32'(opcode), 32'd2);
        check("op2_illegal", 32'(illegal_op), 32'd1);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("op2_stall_valid", 32'(instr_valid), 32'd1);
            check("op2_stall_no_req", 32'(imem_req), 32'd0);
            check("op2_stall_pc", pc, 32'h200);
        end
        redirect_en = 1'b1;
        redirect_pc = 32'h0;
        tick();
        redirect_en = 1'b0;
        expect_stall = 1'b0;
        check("op2_clear_illegal", 32'(illegal_op), 32'd0);
        check("op2_resume_addr", imem_addr, 32'h0);
        exp_q.push_back(32'h0);
        tick();
        check("op2_resume_pc", pc, 32'h0);
        check("op2_resume_legal", 32'(illegal_op), 32'd0);
        tick();
`else
        exp_q.push_back(32'h200);
        tick();
        check("op2_opcode", 32'(opcode), 32'd2);
        tick();
        check("op2_next_addr", imem_addr, 32'h204);
`endif

        // reset aborts an outstanding request
        lat = 5;
        tick();
        tick();
        check("abort_pre_state", 32'(dbg_state), 32'(FETCH));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        instr_accept = 1'b0;
        check("abort_addr", imem_addr, 32'h0);
        check("abort_req", 32'(imem_req), 32'd1);
        check("abort_valid", 32'(instr_valid), 32'd0);
        check("abort_pc", pc, 32'd0);
        check("abort_instr", instr, 32'd0);
        tick();
        tick();

        check("sb_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
